fnd_4digit_scan: RTL and testbench
==================================

Name: fnd_4digit_scan

Overview:
Downstream display stage for the watch, cook-timer and stop-watch blocks. It takes two binary 8-bit display values (hi pair = min/sec, lo pair = sec/c_sec) and converts each to two BCD digits. It drives a 4-digit, common-anode, multiplexed 7-segment FND with per-digit blink and a decimal point. Values are captured once per scan frame so the display never shows a torn mix of old and new digits.

Parameters:
SCAN_DIV, 100_000, clk cycles each digit is driven (1 ms at 100 MHz); legal range >= 2
BLINK_DIV, 50_000_000, clk cycles per blink half-period (0.5 s at 100 MHz); legal range >= 2
LEAD_ZERO_BLANK, 0, 1 = blank digit 3 when its BCD value is 0

Ports:
clk  input  1  system clock
reset_p  input  1  synchronous active-high reset
value_hi  input  8  binary value shown on digits 3:2
value_lo  input  8  binary value shown on digits 1:0
blink_mask  input  4  bit n = 1: digit n blinks
dp_en  input  1  1 = decimal point lit on digit 2
com  output  4  digit enables, active-low; com[0] = rightmost digit
seg_7  output  8  {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (reset_p), sampled only on the rising edge of clk.
- Reset values:
  - com = 4'b1111, seg_7 = 8'hFF
  - scan counter = 0, digit index = 0
  - blink counter = 0, blink phase = 0 (visible)
  - captured hi/lo = 0
- Scan:
  - Scan counter runs 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps and the digit index advances 0→1→2→3→0.
  - Digit map: 0 = lo ones, 1 = lo tens, 2 = hi ones, 3 = hi tens.
- Capture:
  - value_hi and value_lo are latched only in the cycle where scan counter = SCAN_DIV-1 and digit index = 3.
  - The latched values are used for the whole of the next frame. Input changes mid-frame have no effect until the next frame.
  - Worst-case input-to-display latency: 4*SCAN_DIV + 1 cycles.
- Arithmetic:
  - A latched value above 99 saturates to 99 before BCD conversion.
  - tens = v/10 and ones = v%10, from a combinational conversion of the latched value.
- Segment codes (active-low, dp bit = 1): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90.
- Decimal point: bit 7 = 0 only when the digit index is 2 and dp_en = 1. dp_en is sampled live, not captured.
- Blink:
  - Blink counter runs 0..BLINK_DIV-1; the phase toggles on each wrap.
  - When phase = 1 and blink_mask[idx] = 1, com = 4'b1111 and seg_7 = 8'hFF for that slot.
  - blink_mask is sampled live.
- Leading-zero blank: when LEAD_ZERO_BLANK = 1, digit index = 3 and hi tens = 0, that slot outputs com = 4'b1111 and seg_7 = 8'hFF.
- Output timing:
  - com and seg_7 are registered, one cycle after the index and counter state they reflect.
  - Exactly one com bit is low at any time, except in blanked slots.
  - First cycle after reset release: com = 4'b1110, seg_7 = C0.
- Reset mid-operation: on the next clock edge all state returns to its reset values. A reset_p pulse with no clock edge has no effect.

Test Plan:
1. SCAN_DIV=4, BLINK_DIV=64. Assert reset_p for 3 cycles, then release with inputs 0 and dp_en=1 -> during reset com=F, seg_7=FF. After release, each held for 4 cycles: com 1110/C0, 1101/C0, 1011/40, 0111/C0.
2. Set value_hi=12, value_lo=34 in the middle of digit 1 -> the rest of that frame still shows 00.00. From the next frame, com 1110/99, 1101/B0, 1011/24 (dp_en=1), 0111/F9.
3. Set value_lo=150, value_hi=255 -> the next frame shows 99.99: digits 0,1,3 = 90; digit 2 = 10 with dp.
4. blink_mask=4'b0011, value 12/34 -> for cycles 64..127 com[1:0] are never low and the other slots are unchanged. For cycles 128..191 all four digits are scanned normally.
5. LEAD_ZERO_BLANK=1, value_hi=5 -> the digit-3 slot gives com=1111/FF. Digit 2 shows 92, or 12 with dp.
6. Assert reset_p for 1 cycle mid-frame with value 12/34 -> the next edge gives com=F and seg_7=FF. After release the display shows 00.00 for one full frame, then 12.34.

Source files
------------

// File: rtl/fnd_4digit_scan.sv
// rtl/fnd_4digit_scan.sv - 4-digit multiplexed 7-segment (FND) scanner with blink and decimal point
//
// Purpose:
//   Takes two binary display values, converts each one to two BCD digits and
//   drives a common-anode, 4-digit, multiplexed 7-segment display. The inputs
//   are captured once per scan frame, so a frame never shows a mix of old and
//   new values.
//
// Ports:
//   clk        : system clock
//   reset_p    : synchronous active-high reset
//   value_hi   : binary value shown on digits 3:2 (saturated to 99)
//   value_lo   : binary value shown on digits 1:0 (saturated to 99)
//   blink_mask : bit n = 1 makes digit n blink
//   dp_en      : 1 = decimal point lit on digit 2 (sampled live)
//   com        : digit enables, active-low, com[0] = rightmost digit
//   seg_7      : {dp,g,f,e,d,c,b,a}, active-low
module fnd_4digit_scan #(
  parameter int unsigned SCAN_DIV        = 100_000,
  parameter int unsigned BLINK_DIV       = 50_000_000,
  parameter bit          LEAD_ZERO_BLANK = 1'b0
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [7:0] value_hi,
  input  logic [7:0] value_lo,
  input  logic [3:0] blink_mask,
  input  logic       dp_en,
  output logic [3:0] com,
  output logic [7:0] seg_7
);

  localparam int unsigned SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // Digit scan sequencer: one state per digit slot.
  typedef enum logic [1:0] {
    DIG0 = 2'd0,  // lo ones
    DIG1 = 2'd1,  // lo tens
    DIG2 = 2'd2,  // hi ones
    DIG3 = 2'd3   // hi tens
  } digit_e;

  digit_e digit_q;
  digit_e digit_d;

  logic [SCAN_W-1:0]  scan_cnt;
  logic               scan_wrap;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [7:0]         cap_hi;
  logic [7:0]         cap_lo;

  logic [6:0] sat_hi;
  logic [6:0] sat_lo;
  logic [3:0] hi_tens;
  logic [3:0] hi_ones;
  logic [3:0] lo_tens;
  logic [3:0] lo_ones;
  logic [3:0] cur_digit;
  logic       blank;
  logic [3:0] com_d;
  logic [7:0] seg_d;

  // Binary (0..99) to {tens, ones}; repeated subtraction keeps it to small comparators.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [6:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, 4'(rem)};
  endfunction

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 is dark.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign scan_wrap = (scan_cnt == SCAN_LAST);

  // Scan counter: time each digit is driven.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      scan_cnt <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Digit sequencer state register.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      digit_q <= DIG0;
    end else begin
      digit_q <= digit_d;
    end
  end

  // Digit sequencer next state: advance only when the current slot expires.
  always_comb begin
    digit_d = digit_q;
    if (scan_wrap) begin
      case (digit_q)
        DIG0:    digit_d = DIG1;
        DIG1:    digit_d = DIG2;
        DIG2:    digit_d = DIG3;
        DIG3:    digit_d = DIG0;
        default: digit_d = DIG0;
      endcase
    end
  end

  // Blink timebase; phase 1 = blinking digits are dark.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Capture at the very last cycle of a frame so the next frame starts with
  // fresh, self-consistent values and keeps them until it ends.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      cap_hi <= 8'd0;
      cap_lo <= 8'd0;
    end else if (scan_wrap && (digit_q == DIG3)) begin
      cap_hi <= value_hi;
      cap_lo <= value_lo;
    end
  end

  assign sat_hi = (cap_hi > 8'd99) ? 7'd99 : cap_hi[6:0];
  assign sat_lo = (cap_lo > 8'd99) ? 7'd99 : cap_lo[6:0];

  assign {hi_tens, hi_ones} = to_bcd(sat_hi);
  assign {lo_tens, lo_ones} = to_bcd(sat_lo);

  always_comb begin
    cur_digit = lo_ones;
    blank     = 1'b0;
    com_d     = 4'b1111;
    seg_d     = 8'hFF;

    case (digit_q)
      DIG0:    cur_digit = lo_ones;
      DIG1:    cur_digit = lo_tens;
      DIG2:    cur_digit = hi_ones;
      DIG3:    cur_digit = hi_tens;
      default: cur_digit = lo_ones;
    endcase

    if (blink_phase && blink_mask[digit_q]) begin
      blank = 1'b1;
    end
    if (LEAD_ZERO_BLANK && (digit_q == DIG3) && (hi_tens == 4'd0)) begin
      blank = 1'b1;
    end

    if (!blank) begin
      com_d = ~(4'b0001 << digit_q);
      seg_d = {~(dp_en && (digit_q == DIG2)), seg_code(cur_digit)};
    end
  end

  // Registered outputs: one cycle behind the scan state they represent.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      com   <= 4'b1111;
      seg_7 <= 8'hFF;
    end else begin
      com   <= com_d;
      seg_7 <= seg_d;
    end
  end

endmodule

// File: tb/tb_fnd_4digit_scan.sv
// tb/tb_fnd_4digit_scan.sv - self-checking bench for fnd_4digit_scan
module tb_fnd_4digit_scan;

  localparam int SD = 4;
  localparam int BD = 64;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic [7:0] value_hi = 8'd0;
  logic [7:0] value_lo = 8'd0;
  logic [3:0] blink_mask = 4'd0;
  logic       dp_en = 1'b1;

  logic [3:0] com_a;
  logic [7:0] seg_a;
  logic [3:0] com_b;
  logic [7:0] seg_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fnd_4digit_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD), .LEAD_ZERO_BLANK(1'b0)) dut_a (
    .clk(clk), .reset_p(reset_p), .value_hi(value_hi), .value_lo(value_lo),
    .blink_mask(blink_mask), .dp_en(dp_en), .com(com_a), .seg_7(seg_a)
  );

  fnd_4digit_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD), .LEAD_ZERO_BLANK(1'b1)) dut_b (
    .clk(clk), .reset_p(reset_p), .value_hi(value_hi), .value_lo(value_lo),
    .blink_mask(blink_mask), .dp_en(dp_en), .com(com_b), .seg_7(seg_b)
  );

  typedef struct {
    logic [3:0] com_a;
    logic [7:0] seg_a;
    logic [3:0] com_b;
    logic [7:0] seg_b;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] ref_seg(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Reference model: s counts clock edges since reset release.
  int         m_s = 0;
  logic [7:0] m_hi = 8'd0;
  logic [7:0] m_lo = 8'd0;
  int         m_idx, m_ph, m_vh, m_vl, m_d;
  logic [7:0] m_seg;
  logic [3:0] m_com;
  logic       m_blink;
  exp_t       m_e;

  always @(posedge clk) begin
    if (reset_p) begin
      m_e = '{4'hF, 8'hFF, 4'hF, 8'hFF};
      m_s = 0;
      m_hi = 8'd0;
      m_lo = 8'd0;
    end else begin
      m_idx = (m_s / SD) % 4;
      m_ph  = (m_s / BD) % 2;
      m_vh  = (m_hi > 8'd99) ? 99 : int'(m_hi);
      m_vl  = (m_lo > 8'd99) ? 99 : int'(m_lo);
      case (m_idx)
        0: m_d = m_vl % 10;
        1: m_d = m_vl / 10;
        2: m_d = m_vh % 10;
        default: m_d = m_vh / 10;
      endcase
      m_seg = ref_seg(m_d);
      if (m_idx == 2 && dp_en) m_seg[7] = 1'b0;
      m_com = ~(4'b0001 << m_idx);
      m_blink = (m_ph == 1) && blink_mask[m_idx];
      m_e.com_a = m_blink ? 4'hF : m_com;
      m_e.seg_a = m_blink ? 8'hFF : m_seg;
      if (m_blink || (m_idx == 3 && (m_vh / 10) == 0)) begin
        m_e.com_b = 4'hF;
        m_e.seg_b = 8'hFF;
      end else begin
        m_e.com_b = m_com;
        m_e.seg_b = m_seg;
      end
      if (m_s % (4 * SD) == 4 * SD - 1) begin
        m_hi = value_hi;
        m_lo = value_lo;
      end
      m_s++;
    end
    exp_q.push_back(m_e);
  end

  exp_t c_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      c_e = exp_q.pop_front();
      chk("com_a", {4'h0, com_a}, {4'h0, c_e.com_a});
      chk("seg_a", seg_a, c_e.seg_a);
      chk("com_b", {4'h0, com_b}, {4'h0, c_e.com_b});
      chk("seg_b", seg_b, c_e.seg_b);
    end
  end

  initial begin
    // 1: reset, then all-zero display with dp on digit 2
    repeat (3) @(negedge clk);
    chk("reset_com", {4'h0, com_a}, 8'h0F);
    chk("reset_seg", seg_a, 8'hFF);
    reset_p = 1'b0;
    @(negedge clk);
    chk("first_com", {4'h0, com_a}, 8'h0E);
    chk("first_seg", seg_a, 8'hC0);
    repeat (4) @(negedge clk);

    // 2: change inputs mid digit 1; takes effect next frame
    value_hi = 8'd12;
    value_lo = 8'd34;
    repeat (40) @(negedge clk);

    // 3: saturation
    value_lo = 8'd150;
    value_hi = 8'd255;
    repeat (40) @(negedge clk);

    // 4: blink on digits 1:0 across several blink half-periods
    value_hi = 8'd12;
    value_lo = 8'd34;
    blink_mask = 4'b0011;
    repeat (150) @(negedge clk);
    blink_mask = 4'b0100;
    repeat (70) @(negedge clk);
    blink_mask = 4'b0000;

    // 5: leading-zero blank (dut_b), dp toggled live
    value_hi = 8'd5;
    repeat (24) @(negedge clk);
    dp_en = 1'b0;
    repeat (24) @(negedge clk);
    dp_en = 1'b1;

    // reset pulse between clock edges has no effect
    #1 reset_p = 1'b1;
    #1 reset_p = 1'b0;
    repeat (8) @(negedge clk);

    // 6: one-cycle reset mid-frame
    value_hi = 8'd12;
    value_lo = 8'd34;
    repeat (22) @(negedge clk);
    reset_p = 1'b1;
    @(negedge clk);
    chk("midreset_com", {4'h0, com_a}, 8'h0F);
    chk("midreset_seg", seg_a, 8'hFF);
    reset_p = 1'b0;
    @(negedge clk);
    chk("postreset_com", {4'h0, com_a}, 8'h0E);
    chk("postreset_seg", seg_a, 8'hC0);
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
